// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module   : prbs_gen_chk
// Brief    : Runtime-selectable PRBS7/15/23/31 serial generator plus a
//            self-synchronising checker with lock tracking and a saturating
//            error counter. Optional generator error injection is compiled
//            in when the macro PRBS_ERR_INJ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_gen_chk #(
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 32,
    parameter int LOSS_CNT  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic                 gen_en,
    input  logic                 seed_ld,
    input  logic [30:0]          seed,
    input  logic                 inj_err,
    output logic                 gen_out,
    input  logic                 chk_en,
    input  logic                 chk_in,
    input  logic                 err_clr,
    output logic                 chk_locked,
    output logic                 chk_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [0:0] c_ST_UNLOCKED = 1'b0;
    localparam logic [0:0] c_ST_LOCKED   = 1'b1;
    localparam logic [7:0] c_LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] c_LOSS_LAST   = 8'(LOSS_CNT - 1);

    // Polynomial selection (shared by generator and checker)
    logic [4:0]  w_order;
    logic [4:0]  w_tap_a;
    logic [4:0]  w_tap_b;
    logic [30:0] w_mask;

    // Generator
    logic [30:0] r_s;
    logic        r_gen_out;
    logic        w_gen_fb;
    logic        w_gen_zero;
    logic        w_gen_adv;
    logic [30:0] w_seed_masked;
    logic        w_inject;

    // Checker
    logic [30:0]          r_c;
    logic [4:0]           r_fill;
    logic [7:0]           r_good;
    logic [7:0]           r_bad;
    logic [0:0]           r_state;
    logic [1:0]           r_mode;
    logic                 r_chk_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [30:0]          w_c_shift;
    logic                 w_c_zero;
    logic                 w_chk_mis;
    logic                 w_full;
    logic                 w_mode_chg;
    logic [4:0]           w_fill_nxt;
    logic [7:0]           w_good_nxt;
    logic [7:0]           w_bad_nxt;
    logic [0:0]           w_state_nxt;
    logic                 w_err_hit;

    // Order, tap indices (a-1, b-1) and state mask for the selected polynomial
    always_comb begin
        w_order = 5'd7;
        w_tap_a = 5'd6;
        w_tap_b = 5'd5;
        w_mask  = 31'h0000_007F;
        case (mode)
            2'b00: begin w_order = 5'd7;  w_tap_a = 5'd6;  w_tap_b = 5'd5;  w_mask = 31'h0000_007F; end
            2'b01: begin w_order = 5'd15; w_tap_a = 5'd14; w_tap_b = 5'd13; w_mask = 31'h0000_7FFF; end
            2'b10: begin w_order = 5'd23; w_tap_a = 5'd22; w_tap_b = 5'd17; w_mask = 31'h007F_FFFF; end
            default: begin w_order = 5'd31; w_tap_a = 5'd30; w_tap_b = 5'd27; w_mask = 31'h7FFF_FFFF; end
        endcase
    end

    assign w_gen_fb      = r_s[w_tap_a] ^ r_s[w_tap_b];
    assign w_gen_zero    = (r_s & w_mask) == 31'd0;
    assign w_gen_adv     = gen_en & ~seed_ld;
    assign w_seed_masked = seed & w_mask;

`ifdef PRBS_ERR_INJ_EN
    logic r_inj_pend;

    // Sticky injection request; consumed by the next generator advance,
    // extra requests while pending are absorbed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inj_pend <= 1'b0;
        end else if (w_gen_adv && r_inj_pend) begin
            r_inj_pend <= 1'b0;
        end else if (inj_err) begin
            r_inj_pend <= 1'b1;
        end
    end

    assign w_inject = r_inj_pend;
`else
    logic w_unused_inj;

    assign w_unused_inj = inj_err;
    assign w_inject     = 1'b0;
`endif

    // Generator LFSR: seed load wins over advance; an all-zero state in the
    // active order is forced back to 1 so the LFSR can never stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s       <= 31'd1;
            r_gen_out <= 1'b0;
        end else if (seed_ld) begin
            r_s <= (w_seed_masked == 31'd0) ? 31'd1 : w_seed_masked;
        end else begin
            if (gen_en) begin
                r_gen_out <= w_gen_fb ^ w_inject;
            end
            if (w_gen_zero) begin
                r_s <= 31'd1;
            end else if (gen_en) begin
                r_s <= {r_s[29:0], w_gen_fb};
            end
        end
    end

    assign w_c_shift  = {r_c[29:0], chk_in};
    assign w_c_zero   = (w_c_shift & w_mask) == 31'd0;
    assign w_chk_mis  = chk_in ^ (r_c[w_tap_a] ^ r_c[w_tap_b]);
    assign w_full     = (r_fill == w_order);
    assign w_mode_chg = (mode != r_mode);

    // Lock FSM next state, run counters and locked-mismatch detection
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err_hit   = 1'b0;
        if (w_mode_chg) begin
            w_fill_nxt  = 5'd0;
            w_good_nxt  = 8'd0;
            w_bad_nxt   = 8'd0;
            w_state_nxt = c_ST_UNLOCKED;
        end else if (chk_en) begin
            if (!w_full) begin
                w_fill_nxt = r_fill + 5'd1;
            end else if (w_c_zero) begin
                // An all-zero history would predict zeros forever; never trust it
                w_good_nxt  = 8'd0;
                w_bad_nxt   = 8'd0;
                w_state_nxt = c_ST_UNLOCKED;
            end else begin
                case (r_state)
                    c_ST_UNLOCKED: begin
                        if (w_chk_mis) begin
                            w_good_nxt = 8'd0;
                        end else begin
                            w_good_nxt = r_good + 8'd1;
                            if (r_good == c_LOCK_LAST) begin
                                w_state_nxt = c_ST_LOCKED;
                                w_bad_nxt   = 8'd0;
                            end
                        end
                    end
                    default: begin
                        if (w_chk_mis) begin
                            w_err_hit = 1'b1;
                            w_bad_nxt = r_bad + 8'd1;
                            if (r_bad == c_LOSS_LAST) begin
                                w_state_nxt = c_ST_UNLOCKED;
                                w_good_nxt  = 8'd0;
                            end
                        end else begin
                            w_bad_nxt = 8'd0;
                        end
                    end
                endcase
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Checker history, counters, mode copy, error pulse and saturating count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c       <= 31'd0;
            r_fill    <= 5'd0;
            r_good    <= 8'd0;
            r_bad     <= 8'd0;
            r_mode    <= mode;
            r_chk_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (chk_en) begin
                r_c <= w_c_shift;
            end
            r_fill    <= w_fill_nxt;
            r_good    <= w_good_nxt;
            r_bad     <= w_bad_nxt;
            r_mode    <= mode;
            r_chk_err <= w_err_hit;
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_err_hit && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign gen_out    = r_gen_out;
    assign chk_locked = (r_state == c_ST_LOCKED);
    assign chk_err    = r_chk_err;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
